// File: rtl/cost_table_pkg.sv
// Shared types and constants for the cost table server.
// The server's optional query statistics are built only when COST_TABLE_STATS_EN is defined.
package cost_table_pkg;

  // Table geometry. N_IDX must be a power of two so that {W,J} is the row-major index.
  localparam int N_IDX     = 8;
  localparam int IDX_W     = 3;
  localparam int COST_W    = 7;
  localparam int TBL_DEPTH = N_IDX * N_IDX;
  localparam int TBL_IDX_W = $clog2(TBL_DEPTH);
  localparam int QCNT_W    = 16;

  typedef logic [COST_W-1:0]    cost_t;
  typedef logic [TBL_IDX_W-1:0] tbl_idx_t;
  typedef logic [IDX_W-1:0]     idx_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    LOAD  = 2'd1,
    SERVE = 2'd2
  } srv_state_e;

  // Index of the final beat of a load.
  localparam tbl_idx_t TBL_LAST = tbl_idx_t'(TBL_DEPTH - 1);

  // Row-major table index N_IDX*w + j; with N_IDX a power of two this is a plain concatenation.
  function automatic tbl_idx_t tbl_addr(input idx_t w, input idx_t j);
    return {w, j};
  endfunction

endpackage

// File: rtl/cost_table_mem.sv
// Cost table storage: one synchronous write port and one asynchronous read port.
// The read address is registered by the caller, so a synchronous SRAM macro with an
// internal address register can later replace this block without changing read latency.
// The storage has no reset; its contents are undefined until they are written.
module cost_table_mem
  import cost_table_pkg::*;
(
  input  logic     clk_i,
  input  logic     we_i,
  input  tbl_idx_t waddr_i,
  input  cost_t    wdata_i,
  input  tbl_idx_t raddr_i,
  output cost_t    rdata_o
);

  cost_t mem_q [TBL_DEPTH];

  // Write one entry per accepted load beat.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Asynchronous read from the registered address.
  always_comb begin
    rdata_o = mem_q[raddr_i];
  end

endmodule

// File: rtl/cost_table_server.sv
// Cost table server: responder side of the JAM cost-lookup interface.
// Holds an N_IDX x N_IDX table filled by a row-major streamed load, then answers every
// (W,J) request with Cost one cycle later. Cost stays 0 until a full load completes.
// Optional build macro: COST_TABLE_STATS_EN adds a saturating query_count output.
module cost_table_server
  import cost_table_pkg::*;
(
  input  logic              CLK,
  input  logic              RST,
  input  logic [IDX_W-1:0]  W,
  input  logic [IDX_W-1:0]  J,
  output logic [COST_W-1:0] Cost,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic [COST_W-1:0] load_data,
  output logic              load_ready,
  output logic              table_ready
`ifdef COST_TABLE_STATS_EN
  ,
  output logic [QCNT_W-1:0] query_count
`endif
);

  srv_state_e state_q;
  tbl_idx_t   idx_q;
  idx_t       w_q;
  idx_t       j_q;
  logic       table_ready_q;

  logic       load_ready_s;
  logic       wr_en_s;
  tbl_idx_t   raddr_s;
  cost_t      rdata_s;
  cost_t      cost_s;

  // A beat is only taken in LOAD and never on a restart cycle, so a coincident
  // load_valid beat is dropped when load_start is high.
  always_comb begin
    if (state_q == LOAD) begin
      load_ready_s = ~load_start;
    end else begin
      load_ready_s = 1'b0;
    end
    wr_en_s = load_valid & load_ready_s;
    raddr_s = tbl_addr(w_q, j_q);
  end

  // Load sequencer and request address register; table_ready is registered with the state.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q       <= EMPTY;
      idx_q         <= '0;
      w_q           <= '0;
      j_q           <= '0;
      table_ready_q <= 1'b0;
    end else begin
      w_q <= W;
      j_q <= J;
      case (state_q)
        EMPTY: begin
          if (load_start) begin
            state_q <= LOAD;
            idx_q   <= '0;
          end
        end
        LOAD: begin
          if (load_start) begin
            idx_q <= '0;
          end else if (load_valid) begin
            if (idx_q == TBL_LAST) begin
              state_q       <= SERVE;
              idx_q         <= '0;
              table_ready_q <= 1'b1;
            end else begin
              idx_q <= idx_q + tbl_idx_t'(1);
            end
          end
        end
        SERVE: begin
          if (load_start) begin
            state_q       <= LOAD;
            idx_q         <= '0;
            table_ready_q <= 1'b0;
          end
        end
        default: begin
          state_q       <= EMPTY;
          idx_q         <= '0;
          table_ready_q <= 1'b0;
        end
      endcase
    end
  end

  cost_table_mem u_mem (
    .clk_i   (CLK),
    .we_i    (wr_en_s),
    .waddr_i (idx_q),
    .wdata_i (load_data),
    .raddr_i (raddr_s),
    .rdata_o (rdata_s)
  );

  // Gate the looked-up cost so partially loaded or stale contents never reach JAM.
  always_comb begin
    if (state_q == SERVE) begin
      cost_s = rdata_s;
    end else begin
      cost_s = '0;
    end
  end

  assign Cost        = cost_s;
  assign load_ready  = load_ready_s;
  assign table_ready = table_ready_q;

`ifdef COST_TABLE_STATS_EN
  logic [QCNT_W-1:0] qcnt_q;
  logic              addr_chg_s;

  // A new query is any cycle where the presented address differs from the held one.
  always_comb begin
    if ({W, J} != {w_q, j_q}) begin
      addr_chg_s = 1'b1;
    end else begin
      addr_chg_s = 1'b0;
    end
  end

  // Saturating count of distinct queries while serving; cleared when a load begins.
  always_ff @(posedge CLK) begin
    if (RST) begin
      qcnt_q <= '0;
    end else if (load_start) begin
      qcnt_q <= '0;
    end else if ((state_q == SERVE) && addr_chg_s && (qcnt_q != 16'hFFFF)) begin
      qcnt_q <= qcnt_q + 16'd1;
    end
  end

  assign query_count = qcnt_q;
`endif

endmodule

// File: tb/tb_cost_table_server.sv
// Self-checking bench for cost_table_server: a table-level reference model plus
// directed load/query sequences with hand-computed literal expectations.
module tb_cost_table_server;

  logic       clk;
  logic       rst;
  logic [2:0] w_in;
  logic [2:0] j_in;
  logic [6:0] cost;
  logic       load_start;
  logic       load_valid;
  logic [6:0] load_data;
  logic       load_ready;
  logic       table_ready;
`ifdef COST_TABLE_STATS_EN
  logic [15:0] query_count;
`endif

  cost_table_server dut (
    .CLK         (clk),
    .RST         (rst),
    .W           (w_in),
    .J           (j_in),
    .Cost        (cost),
    .load_start  (load_start),
    .load_valid  (load_valid),
    .load_data   (load_data),
    .load_ready  (load_ready),
    .table_ready (table_ready)
`ifdef COST_TABLE_STATS_EN
    ,
    .query_count (query_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit check_en = 1'b0;
  int acc_beats = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: phase 0=empty, 1=loading, 2=serving; count = beats received so far.
  int         m_phase = 0;
  int         m_count = 0;
  int         m_pw = 0;
  int         m_pj = 0;
  logic [6:0] m_tbl [64];

  // Model update from the inputs seen at each rising edge.
  always @(posedge clk) begin
    if (rst) begin
      m_phase <= 0;
      m_count <= 0;
      m_pw    <= 0;
      m_pj    <= 0;
    end else begin
      m_pw <= int'(w_in);
      m_pj <= int'(j_in);
      if (load_start) begin
        m_phase <= 1;
        m_count <= 0;
      end else if (m_phase == 1 && load_valid) begin
        m_tbl[m_count] <= load_data;
        if (m_count == 63) begin
          m_phase <= 2;
          m_count <= 0;
        end else begin
          m_count <= m_count + 1;
        end
      end
    end
  end

  // Every-cycle comparison of the DUT outputs against the model.
  always @(negedge clk) begin
    if (check_en) begin
      chk("cost", int'(cost), (m_phase == 2) ? int'(m_tbl[m_pw * 8 + m_pj]) : 0);
      chk("table_ready", int'(table_ready), (m_phase == 2) ? 1 : 0);
      chk("load_ready", int'(load_ready), (m_phase == 1 && !load_start) ? 1 : 0);
    end
  end

  // Count beats actually accepted by the handshake.
  always @(negedge clk) begin
    if (load_valid && load_ready) acc_beats++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_load();
    load_start = 1'b1;
    load_valid = 1'b0;
    tick();
    load_start = 1'b0;
  endtask

  task automatic load_const(input logic [6:0] v);
    for (int i = 0; i < 64; i++) begin
      load_valid = 1'b1;
      load_data  = v;
      tick();
    end
    load_valid = 1'b0;
  endtask

  task automatic query(input int p);
    w_in = 3'(p / 8);
    j_in = 3'(p % 8);
    tick();
  endtask

  task automatic sweep_expect(input string nm, input int v);
    for (int p = 0; p < 64; p++) begin
      query(p);
      @(negedge clk);
      chk(nm, int'(cost), v);
    end
  endtask

  initial begin
    rst = 1'b1;
    w_in = 3'd0;
    j_in = 3'd0;
    load_start = 1'b0;
    load_valid = 1'b0;
    load_data = 7'd0;
    tick();
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_cost", int'(cost), 0);
    chk("rst_table_ready", int'(table_ready), 0);
    chk("rst_load_ready", int'(load_ready), 0);
    check_en = 1'b1;

    // Gap-free load of idx mod 100.
    start_load();
    acc_beats = 0;
    for (int i = 0; i < 64; i++) begin
      load_valid = 1'b1;
      load_data  = 7'(i % 100);
      tick();
    end
    load_valid = 1'b0;
    @(negedge clk);
    chk("beats_accepted", acc_beats, 64);
    chk("ready_after_last", int'(table_ready), 1);
    query(3 * 8 + 5);
    @(negedge clk);
    chk("cost_w3_j5", int'(cost), 29);

    // Back-to-back sweep, checked every cycle by the model compare.
    for (int p = 0; p < 64; p++) query(p);
    for (int p = 63; p >= 0; p--) query(p);

    // Load with alternating gaps; 64th value is 127.
    start_load();
    for (int c = 0; c < 128; c++) begin
      load_valid = (c % 2 == 0);
      load_data  = 7'(64 + c / 2);
      tick();
    end
    load_valid = 1'b0;
    query(63);
    @(negedge clk);
    chk("cost_w7_j7", int'(cost), 127);
    query(0);
    @(negedge clk);
    chk("cost_w0_j0", int'(cost), 64);

    // Restart mid-load: the coincident 99 beat must be discarded.
    start_load();
    for (int i = 0; i < 20; i++) begin
      load_valid = 1'b1;
      load_data  = 7'd5;
      tick();
    end
    load_start = 1'b1;
    load_valid = 1'b1;
    load_data  = 7'd99;
    tick();
    load_start = 1'b0;
    load_const(7'd1);
    @(negedge clk);
    chk("restart_ready", int'(table_ready), 1);
    sweep_expect("restart_cost", 1);

    // Reload from SERVE: outputs drop the next cycle.
    w_in = 3'd2;
    j_in = 3'd6;
    start_load();
    @(negedge clk);
    chk("reload_cost", int'(cost), 0);
    chk("reload_table_ready", int'(table_ready), 0);
    load_const(7'd42);
    sweep_expect("reload_cost42", 42);

    // Reset in the middle of a load returns to the gated state.
    start_load();
    for (int i = 0; i < 10; i++) begin
      load_valid = 1'b1;
      load_data  = 7'd77;
      tick();
    end
    load_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    query(5);
    @(negedge clk);
    chk("midreset_cost", int'(cost), 0);
    chk("midreset_table_ready", int'(table_ready), 0);

`ifdef COST_TABLE_STATS_EN
    w_in = 3'd0;
    j_in = 3'd0;
    start_load();
    load_const(7'd9);
    for (int i = 0; i < 10; i++) tick();
    for (int p = 1; p <= 5; p++) query(p);
    @(negedge clk);
    chk("query_count", int'(query_count), 5);
    start_load();
    @(negedge clk);
    chk("query_count_clr", int'(query_count), 0);
`endif

    tick();
    check_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/cost_table_server.md
Name: cost_table_server

Overview:
- Responder side of the JAM cost-lookup interface.
- Holds the 8x8 worker/job cost table and answers every W/J request with Cost on the following cycle.
- The table is filled by a row-major streamed load phase.
- Sits beside the JAM core as its cost source. It replaces any behavioural cost ROM, so the full system is self-contained RTL.

Parameters:
- N_IDX, 8, number of workers and jobs (table is N_IDX x N_IDX); must be a power of two.
- IDX_W, 3, width of W and J; equals log2(N_IDX).
- COST_W, 7, width of one cost entry.

Ports:
- CLK  input  1  system clock.
- RST  input  1  reset; one clock, synchronous and active-high.
- W  input  IDX_W  worker index requested by JAM.
- J  input  IDX_W  job index requested by JAM.
- Cost  output  COST_W  cost of the (W,J) pair sampled at the previous rising edge.
- load_start  input  1  pulse; begin or restart a table load.
- load_valid  input  1  load_data is valid this cycle.
- load_data  input  COST_W  next table entry, row-major (index = N_IDX*W + J).
- load_ready  output  1  server accepts a load beat this cycle.
- table_ready  output  1  table fully loaded; Cost is meaningful.

Behaviour:
- Reset: state=EMPTY, load index=0, W_r=J_r=0, Cost=0, load_ready=0, table_ready=0. Table storage is not reset.
- Request path, every cycle regardless of state:
  - W_r<=W and J_r<=J on each rising edge.
  - Cost = table[N_IDX*W_r+J_r] when state==SERVE, else 0.
  - Latency is exactly one cycle: an address presented in cycle k yields its cost throughout cycle k+1.
  - No request handshake; JAM may change W/J every cycle.
- FSM states: EMPTY, LOAD, SERVE.
  - EMPTY -> LOAD on load_start.
  - LOAD: load_ready = (state==LOAD) && !load_start.
    - Beat accepted when load_valid && load_ready: table[idx]<=load_data, idx<=idx+1.
    - On the beat with idx==N_IDX*N_IDX-1: go to SERVE and reset idx to 0.
  - SERVE: table_ready=1 (registered; asserted the cycle after the last beat).
  - load_start in LOAD: idx<=0, remain in LOAD; a coincident load_valid beat is discarded.
  - load_start in SERVE: go to LOAD, idx<=0. table_ready and Cost drop to 0 from the next cycle. Old contents are overwritten progressively.
  - load_valid outside LOAD is ignored. Gaps (load_valid=0) inside LOAD are allowed and do not advance idx.
- RST mid-load: return to EMPTY. Partially written entries remain, but Cost is gated to 0 until a full reload completes.
- No arithmetic on cost values; entries are stored and returned bit-exact.

Optional Feature:
- Macro: COST_TABLE_STATS_EN.
- With the macro:
  - Extra output port query_count (16 bits), reset to 0.
  - Increments on each rising edge in SERVE where the sampled {W,J} differs from {W_r,J_r}.
  - Saturates at 16'hFFFF.
  - Cleared to 0 on entry to LOAD.
- Without the macro: the port and counter logic are absent; all other behaviour is identical.

Decomposition:
- Package cost_table_pkg:
  - N_IDX, IDX_W, COST_W defaults.
  - TBL_DEPTH = N_IDX*N_IDX.
  - typedef cost_t (logic [COST_W-1:0]).
  - typedef tbl_idx_t (logic [log2(TBL_DEPTH)-1:0]).
  - enum srv_state_e {EMPTY, LOAD, SERVE}.
- One sub-module: cost_table_mem, a TBL_DEPTH x COST_W array with one write port and one asynchronous read port on a registered address. It isolates the storage so it can later be swapped for a synchronous SRAM macro.

Test Plan:
- Reset, then load entries 0..63 with value = idx mod 100 and no gaps:
  - load_ready=1 for exactly 64 accepted beats.
  - table_ready=1 the cycle after beat 63.
  - W=3,J=5 presented in cycle k gives Cost=29 in cycle k+1.
- Back-to-back sweep of all 64 (W,J) pairs, one per cycle after load: each Cost matches its entry one cycle later, with no bubbles.
- Load with load_valid toggling 1/0 (128 cycles), then query W=7,J=7 -> Cost equals the 64th data value, e.g. 127.
- Restart mid-load:
  - Load 20 beats, pulse load_start with load_valid=1 and data 99 (discarded), then load 64 beats of value 1.
  - Result: table_ready=1 and every Cost=1; 99 never appears.
- Reload from SERVE:
  - After a full table, pulse load_start; the next cycle Cost=0 and table_ready=0.
  - Complete the reload with value 42 -> all Costs=42.
- With COST_TABLE_STATS_EN, hold W/J constant 10 cycles then change every cycle for 5 cycles -> query_count=5. A subsequent load_start clears it to 0.
